// File: rtl/hamming_decoder_stream_if.sv
// Valid/ready stream bundle for the Hamming(7,4) decoder: codeword in, corrected data out.
// master = the environment around the decoder, slave = the decoder itself.
interface hamming_decoder_stream_if;
   logic       in_valid;
   logic       in_ready;
   logic [6:0] in_code;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] out_data;
   logic [2:0] out_syndrome;
   logic       out_err;

   modport master (
      output in_valid, in_code, out_ready,
      input  in_ready, out_valid, out_data, out_syndrome, out_err
   );

   modport slave (
      input  in_valid, in_code, out_ready,
      output in_ready, out_valid, out_data, out_syndrome, out_err
   );
endinterface

// File: rtl/hamming_decoder_stream.sv
// Two-stage Hamming(7,4) single-error-correcting decoder with full backpressure
// and a saturating count of corrected words delivered downstream.
module hamming_decoder_stream #(
   parameter int CNT_W = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   hamming_decoder_stream_if.slave bus,
   input  logic                  clr_cnt,
   output logic [CNT_W-1:0]      corr_cnt
);

   logic             s1_valid_reg;
   logic [6:0]       s1_code_reg;
   logic [2:0]       s1_syn_reg;
   logic             s2_valid_reg;
   logic [3:0]       s2_data_reg;
   logic [2:0]       s2_syn_reg;
   logic             s2_err_reg;
   logic [CNT_W-1:0] cnt_reg;

   logic       adv1;
   logic       adv2;
   logic [2:0] syn_next;
   logic [6:0] flip_mask;
   logic [6:0] fixed_code;
   logic [3:0] data_next;

   assign adv2 = !s2_valid_reg || bus.out_ready;
   assign adv1 = !s1_valid_reg || adv2;

   assign syn_next = {bus.in_code[3] ^ bus.in_code[4] ^ bus.in_code[5] ^ bus.in_code[6],
                      bus.in_code[1] ^ bus.in_code[2] ^ bus.in_code[5] ^ bus.in_code[6],
                      bus.in_code[0] ^ bus.in_code[2] ^ bus.in_code[4] ^ bus.in_code[6]};

   // Syndrome k selects Hamming position k, i.e. bit k-1; k=0 selects nothing.
   genvar gi;
   generate
      for (gi = 0; gi < 7; gi++) begin : g_flip
         assign flip_mask[gi] = (s1_syn_reg == 3'(gi + 1));
      end
   endgenerate

   assign fixed_code = s1_code_reg ^ flip_mask;
   assign data_next  = {fixed_code[6], fixed_code[5], fixed_code[4], fixed_code[2]};

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_reg <= 1'b0;
         s1_code_reg  <= '0;
         s1_syn_reg   <= '0;
      end else if (adv1) begin
         s1_valid_reg <= bus.in_valid;
         s1_code_reg  <= bus.in_code;
         s1_syn_reg   <= syn_next;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid_reg <= 1'b0;
         s2_data_reg  <= '0;
         s2_syn_reg   <= '0;
         s2_err_reg   <= 1'b0;
      end else if (adv2) begin
         s2_valid_reg <= s1_valid_reg;
         s2_data_reg  <= data_next;
         s2_syn_reg   <= s1_syn_reg;
         s2_err_reg   <= (s1_syn_reg != 3'd0);
      end
   end

   // Clear wins over a same-cycle increment; the count sticks at all-ones.
   always_ff @(posedge clk) begin
      if (rst || clr_cnt) begin
         cnt_reg <= '0;
      end else if (s2_valid_reg && bus.out_ready && s2_err_reg && (cnt_reg != {CNT_W{1'b1}})) begin
         cnt_reg <= cnt_reg + CNT_W'(1);
      end
   end

   assign bus.in_ready     = adv1;
   assign bus.out_valid    = s2_valid_reg;
   assign bus.out_data     = s2_data_reg;
   assign bus.out_syndrome = s2_syn_reg;
   assign bus.out_err      = s2_err_reg;
   assign corr_cnt         = cnt_reg;

endmodule

// File: tb/tb_hamming_decoder_stream.sv
// Randomized and directed bench for hamming_decoder_stream against a positional-XOR
// Hamming model; a second instance with a 2-bit counter checks saturation.
module tb_hamming_decoder_stream;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        clr_cnt = 1'b0;
   logic [15:0] corr_cnt;
   logic [1:0]  corr_cnt_small;
   int          mode = 0;   // out_ready policy: 0 always 1, 1 random, 2 always 0
   int          compared = 0;
   int          failed = 0;
   bit          started = 0;

   hamming_decoder_stream_if bus();
   hamming_decoder_stream_if bus2();

   assign bus2.in_valid  = bus.in_valid;
   assign bus2.in_code   = bus.in_code;
   assign bus2.out_ready = bus.out_ready;

   hamming_decoder_stream #(.CNT_W(16)) dut (
      .clk(clk), .rst(rst), .bus(bus), .clr_cnt(clr_cnt), .corr_cnt(corr_cnt)
   );

   hamming_decoder_stream #(.CNT_W(2)) dut_small (
      .clk(clk), .rst(rst), .bus(bus2), .clr_cnt(clr_cnt), .corr_cnt(corr_cnt_small)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] d;
      logic [2:0] s;
      logic       e;
   } exp_t;

   exp_t q[$];
   int   model_cnt = 0;
   int   model_cnt_small = 0;

   // Syndrome = XOR of the Hamming positions of all set bits.
   function automatic logic [2:0] model_syn(input logic [6:0] c);
      int s = 0;
      for (int i = 0; i < 7; i++) if (c[i]) s = s ^ (i + 1);
      return 3'(s);
   endfunction

   function automatic logic [3:0] model_data(input logic [6:0] c);
      logic [6:0] f = c;
      int s = int'(model_syn(c));
      if (s != 0) f[s-1] = ~f[s-1];
      return {f[6], f[5], f[4], f[2]};
   endfunction

   function automatic logic [6:0] enc(input logic [3:0] d);
      logic [6:0] c = '0;
      logic [2:0] s;
      c[2] = d[0]; c[4] = d[1]; c[5] = d[2]; c[6] = d[3];
      s = model_syn(c);
      c[0] = s[0]; c[1] = s[1]; c[3] = s[2];
      return c;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      compared++;
      if (act != exp) begin
         failed++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [6:0] c);
      int   t = 0;
      logic acc = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_code  = c;
      while (!acc && t < 100) begin
         @(negedge clk);
         acc = bus.in_ready;
         @(posedge clk);
         #1;
         t++;
      end
      bus.in_valid = 1'b0;
      chk("push_accepted", int'(acc), 1);
   endtask

   task automatic drain();
      int t = 0;
      while (q.size() != 0 && t < 300) begin
         tick();
         t++;
      end
      chk("drain_empty", q.size(), 0);
   endtask

   // out_ready driver, updated away from the edge and from the main stimulus time.
   initial begin
      bus.out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         case (mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = 1'($urandom_range(0, 1));
            default: bus.out_ready = 1'b0;
         endcase
      end
   end

   // Scoreboard: ordering, field values, stall stability and counter model.
   logic [8:0] held;
   bit         hold_pending = 0;
   always @(posedge clk) begin
      logic hs_err;
      exp_t e;
      if (hold_pending)
         chk("stall_stable", int'({bus.out_valid, bus.out_data, bus.out_syndrome, bus.out_err}), int'(held));
      hold_pending = !rst && bus.out_valid && !bus.out_ready;
      held = {bus.out_valid, bus.out_data, bus.out_syndrome, bus.out_err};
      if (rst) begin
         q.delete();
         model_cnt = 0;
         model_cnt_small = 0;
      end else begin
         hs_err = 1'b0;
         if (bus.out_valid && bus.out_ready) begin
            $display("out data=%h syn=%0d err=%0d cnt=%0d", bus.out_data, bus.out_syndrome, bus.out_err, corr_cnt);
            if (q.size() == 0) begin
               chk("unexpected_output", 1, 0);
            end else begin
               e = q.pop_front();
               chk("out_data", int'(bus.out_data), int'(e.d));
               chk("out_syndrome", int'(bus.out_syndrome), int'(e.s));
               chk("out_err", int'(bus.out_err), int'(e.e));
               hs_err = e.e;
            end
         end
         if (clr_cnt) begin
            model_cnt = 0;
            model_cnt_small = 0;
         end else if (hs_err) begin
            if (model_cnt < 65535) model_cnt++;
            if (model_cnt_small < 3) model_cnt_small++;
         end
         if (bus.in_valid && bus.in_ready) begin
            e.d = model_data(bus.in_code);
            e.s = model_syn(bus.in_code);
            e.e = (e.s != 3'd0);
            q.push_back(e);
         end
      end
   end

   always @(negedge clk) begin
      if (started) begin
         chk("corr_cnt", int'(corr_cnt), model_cnt);
         chk("corr_cnt_small", int'(corr_cnt_small), model_cnt_small);
      end
   end

   initial begin
      logic [6:0] c;
      bus.in_valid = 1'b0;
      bus.in_code  = '0;
      tick(); tick();
      rst = 1'b0;
      started = 1;
      chk("rst_out_valid", int'(bus.out_valid), 0);
      chk("rst_out_fields", int'({bus.out_data, bus.out_syndrome, bus.out_err}), 0);
      chk("rst_in_ready", int'(bus.in_ready), 1);
      chk("rst_corr_cnt", int'(corr_cnt), 0);

      // Model pins.
      chk("model_enc_b", int'(enc(4'hB)), 'h55);
      chk("model_syn_45", int'(model_syn(7'h45)), 5);
      chk("model_data_45", int'(model_data(7'h45)), 'hB);

      // Clean word, latency two edges.
      push(7'h55);
      chk("lat_n1_valid", int'(bus.out_valid), 0);
      tick();
      chk("lat_n2_valid", int'(bus.out_valid), 1);
      chk("clean_data", int'(bus.out_data), 'hB);
      chk("clean_syn", int'(bus.out_syndrome), 0);
      chk("clean_err", int'(bus.out_err), 0);
      tick();
      chk("clean_cnt", int'(corr_cnt), 0);

      // Single data-bit error.
      push(7'h45);
      tick();
      chk("err_data", int'(bus.out_data), 'hB);
      chk("err_syn", int'(bus.out_syndrome), 5);
      chk("err_flag", int'(bus.out_err), 1);
      tick();
      chk("err_cnt", int'(corr_cnt), 1);

      // Clear coinciding with an error-word handshake.
      mode = 2;
      tick();
      push(7'h45);
      tick(); tick();
      chk("clr_stalled_valid", int'(bus.out_valid), 1);
      mode = 0;
      @(posedge clk);
      #2;
      clr_cnt = 1'b1;
      @(posedge clk);
      #1;
      clr_cnt = 1'b0;
      chk("clr_priority_cnt", int'(corr_cnt), 0);
      chk("clr_handshake_done", q.size(), 0);

      // Exhaustive sweep: 16 data values x (clean + 7 single flips).
      for (int d = 0; d < 16; d++) begin
         for (int f = -1; f < 7; f++) begin
            c = enc(4'(d));
            if (f >= 0) c[f] = ~c[f];
            chk("sweep_model_data", int'(model_data(c)), d);
            chk("sweep_model_syn", int'(model_syn(c)), f + 1);
            push(c);
         end
      end
      drain();
      tick();
      chk("sweep_cnt_112", int'(corr_cnt), 112);
      chk("sweep_small_sat", int'(corr_cnt_small), 3);

      // Backpressure: 10 words with a 5-cycle hold-off and random ready.
      mode = 2;
      tick();
      push(enc(4'h3));
      push(enc(4'h7) ^ 7'h10);
      @(negedge clk);
      chk("bp_in_ready_low", int'(bus.in_ready), 0);
      chk("bp_out_valid", int'(bus.out_valid), 1);
      tick(); tick(); tick();
      mode = 1;
      for (int i = 0; i < 8; i++) push(7'($urandom_range(0, 127)));
      mode = 0;
      drain();

      // Random stream with random gaps and random ready.
      mode = 1;
      for (int i = 0; i < 200; i++) begin
         push(7'($urandom_range(0, 127)));
         if ($urandom_range(0, 3) == 0) tick();
      end
      mode = 0;
      drain();

      // Reset with both stages holding error words.
      mode = 2;
      tick();
      push(enc(4'h9) ^ 7'h01);
      push(enc(4'h6) ^ 7'h40);
      chk("mid_pre_valid", int'(bus.out_valid), 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_out_valid", int'(bus.out_valid), 0);
      chk("mid_corr_cnt", int'(corr_cnt), 0);
      chk("mid_in_ready", int'(bus.in_ready), 1);
      mode = 0;
      for (int i = 0; i < 6; i++) tick();
      chk("mid_no_stale", int'(bus.out_valid), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
      $finish;
   end

endmodule
